natural_log: RTL and testbench



---
 rtl/natural_log_pkg.sv | 23 ++
 rtl/lzc_encoder_24.sv | 17 +
 rtl/natural_log.sv | 97 +++++++++
 tb/tb_natural_log.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/natural_log_pkg.sv
// rtl/natural_log_pkg.sv - Q-format widths, ln2 constant and log2 correction table for natural_log
package natural_log_pkg;
   localparam int IN_W  = 24;
   localparam int OUT_W = 12;
   localparam int FRAC  = 8;
   localparam int P_W   = 5;
   localparam int LOG_W = 14;

   localparam int LN2_Q16_DEFAULT   = 45426;
   localparam int OUT_FLOOR_DEFAULT = 4;

   typedef logic signed [LOG_W-1:0] log2_q8_t;

   // round(256*(log2(1+k/16) - k/16)), indexed by the top mantissa nibble
   localparam logic [4:0] CORR_LUT [16] = '{
      5'd0,  5'd6,  5'd12, 5'd15, 5'd18, 5'd20, 5'd22, 5'd22,
      5'd22, 5'd21, 5'd19, 5'd17, 5'd15, 5'd12, 5'd8,  5'd4
   };

   function automatic logic [4:0] corr_lookup(input logic [3:0] k);
      return CORR_LUT[k];
   endfunction
endpackage

// File: rtl/lzc_encoder_24.sv
// rtl/lzc_encoder_24.sv - combinational MSB-index priority encoder with zero flag
module lzc_encoder_24
   import natural_log_pkg::*;
(
   input  logic [IN_W-1:0] value,
   output logic [P_W-1:0]  msb_index,
   output logic            is_zero
);
   always_comb begin
      msb_index = '0;
      is_zero   = (value == '0);
      // later (higher) set bits overwrite earlier ones
      for (int i = 0; i < IN_W; i++) begin
         if (value[i]) msb_index = P_W'(i);
      end
   end
endmodule

// File: rtl/natural_log.sv
// rtl/natural_log.sv - 4-stage Q16.8 -> Q4.8 natural log; LN_LUT_CORR_EN enables mantissa correction LUT
module natural_log
   import natural_log_pkg::*;
#(
   parameter int OUT_FLOOR = OUT_FLOOR_DEFAULT,
   parameter int LN2_Q16   = LN2_Q16_DEFAULT
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  in_8_shifted,
   output logic [OUT_W-1:0] out_8_shifted
);
   localparam logic signed [31:0] LN2_S   = 32'(LN2_Q16);
   localparam logic signed [31:0] OUT_MAX = 32'((1 << OUT_W) - 1);

   logic [IN_W-1:0] s1_x;
   logic            s1_v;

   logic [IN_W-1:0] s2_x;
   logic [P_W-1:0]  s2_p;
   logic            s2_zero;
   logic            s2_v;

   log2_q8_t        s3_log2;
   logic            s3_zero;
   logic            s3_v;

   logic [P_W-1:0]  p_enc;
   logic            zero_enc;

   lzc_encoder_24 u_lzc (
      .value     (s1_x),
      .msb_index (p_enc),
      .is_zero   (zero_enc)
   );

   logic [FRAC-1:0] frac;
   logic [4:0]      corr;
   log2_q8_t        log2_next;

   always_comb begin
      // normalise so the MSB sits at bit IN_W-1, then take the FRAC bits beneath it
      frac = FRAC'((s2_x << (P_W'(IN_W - 1) - s2_p)) >> (IN_W - 1 - FRAC));
`ifdef LN_LUT_CORR_EN
      corr = corr_lookup(frac[FRAC-1 -: 4]);
`else
      corr = '0;
`endif
      log2_next = log2_q8_t'({($signed({1'b0, s2_p}) - 6'sd8), 8'b0})
                + log2_q8_t'({6'b0, frac})
                + log2_q8_t'({9'b0, corr});
   end

   logic signed [31:0] log_ext;
   logic signed [31:0] prod;
   logic signed [31:0] scaled;
   logic [OUT_W-1:0]   result;

   always_comb begin
      log_ext = 32'(s3_log2);
      prod    = log_ext * LN2_S;
      scaled  = prod >>> 16;
      result  = scaled[OUT_W-1:0];
      if (s3_zero || scaled < OUT_FLOOR) begin
         result = OUT_W'(OUT_FLOOR);
      end else if (scaled > OUT_MAX) begin
         result = '1;
      end
   end

   // valid bits keep the output at its reset value until real data reaches stage 4
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_x          <= '0;
         s1_v          <= 1'b0;
         s2_x          <= '0;
         s2_p          <= '0;
         s2_zero       <= 1'b0;
         s2_v          <= 1'b0;
         s3_log2       <= '0;
         s3_zero       <= 1'b0;
         s3_v          <= 1'b0;
         out_8_shifted <= '0;
      end else begin
         s1_x    <= in_8_shifted;
         s1_v    <= 1'b1;
         s2_x    <= s1_x;
         s2_p    <= p_enc;
         s2_zero <= zero_enc;
         s2_v    <= s1_v;
         s3_log2 <= log2_next;
         s3_zero <= s2_zero;
         s3_v    <= s2_v;
         if (s3_v) out_8_shifted <= result;
      end
   end
endmodule

// File: tb/tb_natural_log.sv
// tb/tb_natural_log.sv - self-checking bench for natural_log
module tb_natural_log;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [23:0] in_8_shifted = '0;
   logic [11:0] out_8_shifted;

   int compared = 0;
   int mismatched = 0;

   natural_log dut (
      .clk           (clk),
      .reset         (reset),
      .in_8_shifted  (in_8_shifted),
      .out_8_shifted (out_8_shifted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] x;
      logic [11:0] y;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int corr_of(input int k);
`ifdef LN_LUT_CORR_EN
      real v;
      v = 256.0 * ($ln(1.0 + k / 16.0) / $ln(2.0) - k / 16.0);
      return $rtoi($floor(v + 0.5));
`else
      return 0 * k;
`endif
   endfunction

   function automatic int ref_ln(input int unsigned x);
      int  p;
      int  f;
      int  l2;
      int  r;
      real m;
      if (x == 0) return 4;
      p = 0;
      for (int i = 0; i < 24; i++) if ((x >> i) != 0) p = i;
      m = real'(x) / (2.0 ** p) - 1.0;
      f = $rtoi($floor(m * 256.0));
      l2 = (p - 8) * 256 + f + corr_of(f / 16);
      r = $rtoi($floor(real'(l2) * 45426.0 / 65536.0));
      if (r < 4) r = 4;
      if (r > 4095) r = 4095;
      return r;
   endfunction

   initial begin
      logic [11:0] prev;
      logic [11:0] exp_q[$];
      int unsigned rx;

      vecs[0] = '{x: 24'd256,     y: 12'd4};
      vecs[1] = '{x: 24'h001000,  y: 12'd709};
      vecs[2] = '{x: 24'd512,     y: 12'd177};
      vecs[3] = '{x: 24'd0,       y: 12'd4};
      vecs[4] = '{x: 24'd128,     y: 12'd4};
`ifdef LN_LUT_CORR_EN
      vecs[5] = '{x: 24'hFFFFFF,  y: 12'd2841};
`else
      vecs[5] = '{x: 24'hFFFFFF,  y: 12'd2838};
`endif

      reset = 1'b1;
      tick();
      tick();
      check("reset_out", out_8_shifted, 12'd0);
      in_8_shifted = 24'd256;
      reset = 1'b0;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check("post_reset_hold", out_8_shifted, 12'd0);
      end
      tick();
      check("post_reset_first", out_8_shifted, 12'd4);

      for (int i = 0; i < 6; i++) begin
         prev = out_8_shifted;
         in_8_shifted = vecs[i].x;
         for (int e = 1; e <= 3; e++) begin
            tick();
            check($sformatf("vec%0d_edge%0d_prev", i, e), out_8_shifted, prev);
         end
         tick();
         check($sformatf("vec%0d_result", i), out_8_shifted, vecs[i].y);
         for (int e = 0; e < 2; e++) begin
            tick();
            check($sformatf("vec%0d_stable", i), out_8_shifted, vecs[i].y);
         end
      end

      // back-to-back samples on consecutive clocks
      in_8_shifted = 24'd256;    tick();
      in_8_shifted = 24'h001000; tick();
      in_8_shifted = 24'd512;    tick();
      tick();
      check("b2b_0", out_8_shifted, 12'd4);
      tick();
      check("b2b_1", out_8_shifted, 12'd709);
      tick();
      check("b2b_2", out_8_shifted, 12'd177);

      // reset in the middle of a stream
      in_8_shifted = 24'h001000; tick();
      in_8_shifted = 24'd256;    tick();
      reset = 1'b1;
      tick();
      check("midreset_out", out_8_shifted, 12'd0);
      tick();
      check("midreset_hold", out_8_shifted, 12'd0);
      reset = 1'b0;
      in_8_shifted = 24'd512;
      for (int e = 1; e <= 3; e++) begin
         tick();
         check("midreset_release_hold", out_8_shifted, 12'd0);
      end
      tick();
      check("midreset_release_result", out_8_shifted, 12'd177);

      // randomized stream against the real-arithmetic reference
      for (int i = 0; i < 2000; i++) begin
         rx = $urandom & ((32'd1 << $urandom_range(0, 24)) - 1);
         in_8_shifted = rx[23:0];
         exp_q.push_back(12'(ref_ln(rx & 32'hFFFFFF)));
         tick();
         if (exp_q.size() == 4) begin
            check("random", out_8_shifted, exp_q.pop_front());
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
